// File: rtl/bcd_pkg.sv
// Shared types and constants for the sequential binary-to-BCD converter.
package bcd_pkg;

    localparam int unsigned DIGIT_W = 4;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_e;

    localparam logic [DIGIT_W-1:0] BCD_ADJ_LIMIT      = 4'd5;
    localparam logic [DIGIT_W-1:0] BCD_ADJ_ADD        = 4'd3;
    localparam logic [DIGIT_W-1:0] DEFAULT_BLANK_CODE = 4'hF;

endpackage

// File: rtl/bcd_digit_adj.sv
// One BCD digit correction step of double-dabble: add 3 when the digit is 5 or more,
// so the following left shift carries correctly into the next decimal digit.
module bcd_digit_adj
    import bcd_pkg::*;
(
    input  logic [DIGIT_W-1:0] digit_in,
    output logic [DIGIT_W-1:0] digit_out_c
);

    always_comb begin
        digit_out_c = digit_in;
        if (digit_in >= BCD_ADJ_LIMIT) begin
            digit_out_c = digit_in + BCD_ADJ_ADD;
        end
    end

endmodule

// File: rtl/bin_to_bcd_seq.sv
// Sequential binary-to-BCD converter, one shift-and-add-3 step per cycle.
// Optional build macro LEADING_BLANK_EN replaces leading zero digits with BLANK_CODE.
module bin_to_bcd_seq
    import bcd_pkg::*;
#(
    parameter int unsigned        IN_W       = 8,
    parameter int unsigned        N_DIG      = 4,
    parameter logic [DIGIT_W-1:0] BLANK_CODE = DEFAULT_BLANK_CODE
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [IN_W-1:0]          bin_in,
    input  logic                     start,
    output logic                     ready,
    output logic                     busy,
    output logic                     done,
    output logic [DIGIT_W*N_DIG-1:0] bcd_out
);

    localparam int unsigned BCD_W = DIGIT_W * N_DIG;
    localparam int unsigned CNT_W = $clog2(IN_W) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(IN_W - 1);

`ifdef LEADING_BLANK_EN
    localparam logic BLANK_EN = 1'b1;
`else
    localparam logic BLANK_EN = 1'b0;
`endif

    state_e             state_q, state_d;
    logic [IN_W-1:0]    bin_q, bin_d;
    logic [BCD_W-1:0]   bcd_q, bcd_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [BCD_W-1:0]   bcd_out_q, bcd_out_d;
    logic               done_q, done_d;
    logic               busy_q, busy_d;
    logic               ready_q, ready_d;

    logic [BCD_W-1:0]   adj_c;
    logic [BCD_W-1:0]   shifted_c;
    logic [BCD_W-1:0]   final_c;
    logic               leading_c;
    logic               accept_c;

    // Per-digit add-3 correction applied to the accumulator before each shift
    for (genvar g = 0; g < N_DIG; g++) begin : g_adj
        bcd_digit_adj u_adj (
            .digit_in    (bcd_q[g*DIGIT_W +: DIGIT_W]),
            .digit_out_c (adj_c[g*DIGIT_W +: DIGIT_W])
        );
    end

    assign shifted_c = {adj_c[BCD_W-2:0], bin_q[IN_W-1]};
    assign accept_c  = start && ready_q;

    // Leading-zero blanking of the final result; units digit always shown
    always_comb begin
        final_c   = shifted_c;
        leading_c = BLANK_EN;
        for (int i = int'(N_DIG) - 1; i >= 1; i--) begin
            if (leading_c && (shifted_c[i*DIGIT_W +: DIGIT_W] == '0)) begin
                final_c[i*DIGIT_W +: DIGIT_W] = BLANK_CODE;
            end else begin
                leading_c = 1'b0;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        bin_d     = bin_q;
        bcd_d     = bcd_q;
        cnt_d     = cnt_q;
        bcd_out_d = bcd_out_q;
        done_d    = 1'b0;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (accept_c) begin
                    state_d = S_SHIFT;
                    bin_d   = bin_in;
                    bcd_d   = '0;
                    cnt_d   = '0;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_SHIFT: begin
                bin_d = bin_q << 1;
                bcd_d = shifted_c;
                cnt_d = cnt_q + CNT_W'(1);
                // Result lands in bcd_out together with the done strobe
                if (cnt_q == CNT_LAST) begin
                    state_d   = S_DONE;
                    bcd_out_d = final_c;
                    done_d    = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        ready_d = (state_d != S_SHIFT);
        busy_d  = (state_d == S_SHIFT);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            bin_q     <= '0;
            bcd_q     <= '0;
            cnt_q     <= '0;
            bcd_out_q <= '0;
            done_q    <= 1'b0;
            busy_q    <= 1'b0;
            ready_q   <= 1'b1;
        end else begin
            state_q   <= state_d;
            bin_q     <= bin_d;
            bcd_q     <= bcd_d;
            cnt_q     <= cnt_d;
            bcd_out_q <= bcd_out_d;
            done_q    <= done_d;
            busy_q    <= busy_d;
            ready_q   <= ready_d;
        end
    end

    assign ready   = ready_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign bcd_out = bcd_out_q;

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Directed and randomized bench for bin_to_bcd_seq against a decimal-arithmetic model.
module tb_bin_to_bcd_seq;

    localparam int unsigned IN_W  = 8;
    localparam int unsigned N_DIG = 4;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [7:0]  bin_in;
    logic        ready;
    logic        busy;
    logic        done;
    logic [15:0] bcd_out;

    int          total = 0;
    int          bad   = 0;
    logic [15:0] last_out;

    bin_to_bcd_seq #(
        .IN_W  (IN_W),
        .N_DIG (N_DIG)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .bin_in  (bin_in),
        .start   (start),
        .ready   (ready),
        .busy    (busy),
        .done    (done),
        .bcd_out (bcd_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    // Decimal digits by division; optional blanking of leading zeros
    function automatic logic [15:0] ref_bcd(input int unsigned v);
        logic [15:0] r;
        int unsigned p;
        logic lead;
        r = '0;
        p = 1;
        for (int i = 0; i < 4; i++) begin
            r[i*4 +: 4] = 4'((v / p) % 10);
            p = p * 10;
        end
`ifdef LEADING_BLANK_EN
        lead = 1'b1;
        for (int i = 3; i >= 1; i--) begin
            if (lead && r[i*4 +: 4] == 4'd0) r[i*4 +: 4] = 4'hF;
            else lead = 1'b0;
        end
`else
        lead = 1'b0;
`endif
        return r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Accept v now, check the busy window, return at #1 into the done cycle
    task automatic convert(input logic [7:0] v, input bit keep);
        logic [15:0] exp_v;
        exp_v  = ref_bcd(int'(v));
        start  = 1'b1;
        bin_in = v;
        step();
        start = keep;
        for (int k = 1; k <= 8; k++) begin
            if (k > 1) step();
            chk("busy_shift", busy, 1);
            chk("no_early_done", done, 0);
            chk("ready_low_shift", ready, 0);
            chk("bcd_hold_shift", bcd_out, last_out);
            bin_in = 8'($urandom);
        end
        step();
        chk("done_strobe", done, 1);
        chk("busy_done", busy, 0);
        chk("ready_done", ready, 1);
        chk($sformatf("bcd_of_%0d", v), bcd_out, exp_v);
        last_out = exp_v;
    endtask

    initial begin
        bit seen_done;
        bit b2b;
        int gap;
        logic [7:0] v;

        rst_n    = 1'b0;
        start    = 1'b0;
        bin_in   = '0;
        last_out = '0;

        // Reset
        step();
        step();
        chk("rst_bcd", bcd_out, 16'h0000);
        chk("rst_done", done, 0);
        chk("rst_busy", busy, 0);
        chk("rst_ready", ready, 1);
        rst_n = 1'b1;
        step();
        chk("idle_ready", ready, 1);

        // Max value, then zero and 128
        convert(8'd255, 1'b0);
        step();
        chk("done_one_cycle", done, 0);
        chk("idle_after_done", ready, 1);
        chk("bcd_held", bcd_out, last_out);
        convert(8'd0, 1'b0);
        step();
        convert(8'd128, 1'b0);
        step();

        // start while busy is dropped
        start  = 1'b1;
        bin_in = 8'd10;
        step();
        start = 1'b0;
        step();
        step();
        start  = 1'b1;
        bin_in = 8'd99;
        step();
        start = 1'b0;
        for (int c = 4; c <= 8; c++) begin
            chk("t4_no_done", done, 0);
            chk("t4_hold", bcd_out, last_out);
            step();
        end
        chk("t4_done", done, 1);
        chk("t4_bcd", bcd_out, ref_bcd(10));
        last_out = ref_bcd(10);
        step();
        chk("t4_no_second_done", done, 0);
        chk("t4_not_queued", busy, 0);
        chk("t4_ready", ready, 1);

        // start held: back-to-back without an idle cycle
        convert(8'd128, 1'b1);
        convert(8'd7, 1'b0);
        step();
        chk("t5_strobe_end", done, 0);

        // Reset mid-conversion aborts
        start  = 1'b1;
        bin_in = 8'd200;
        step();
        start = 1'b0;
        step();
        step();
        step();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        chk("abort_bcd", bcd_out, 16'h0000);
        chk("abort_ready", ready, 1);
        chk("abort_busy", busy, 0);
        seen_done = done;
        for (int c = 0; c < 12; c++) begin
            step();
            if (done) seen_done = 1'b1;
        end
        chk("abort_no_done", seen_done, 0);
        last_out = '0;
        convert(8'd42, 1'b0);
        step();

        // Randomized values, gaps and back-to-back requests
        for (int i = 0; i < 30; i++) begin
            v   = 8'($urandom);
            b2b = 1'($urandom_range(0, 1));
            convert(v, b2b);
            if (!b2b) begin
                start = 1'b0;
                gap   = $urandom_range(0, 3);
                for (int g = 0; g < gap; g++) begin
                    bin_in = 8'($urandom);
                    step();
                    chk("gap_no_done", done, 0);
                    chk("gap_hold", bcd_out, last_out);
                    chk("gap_ready", ready, 1);
                end
            end
        end
        start = 1'b0;
        step();
        chk("final_hold", bcd_out, last_out);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
